// File: rtl/m2_block_sequencer.sv
// Milestone 2 block scheduler: walks every 8x8 block of the Y, U and V planes and
// overlaps fetch/IDCT/write-back of neighbouring blocks in a two-stage pipeline.
module m2_block_sequencer #(
    parameter int Y_BLOCK_COLS  = 40,
    parameter int UV_BLOCK_COLS = 20,
    parameter int BLOCK_ROWS    = 30
) (
    input  logic       CLOCK_50_I,
    input  logic       Resetn,
    input  logic       M2_start,
    output logic       M2_done,
    output logic       busy,
    output logic       FS_start,
    output logic       CT_start,
    output logic       CS_start,
    output logic       WS_start,
    input  logic       FS_done,
    input  logic       CT_done,
    input  logic       CS_done,
    input  logic       WS_done,
    output logic [1:0] fs_plane,
    output logic [4:0] fs_row,
    output logic [5:0] fs_col,
    output logic [1:0] ws_plane,
    output logic [4:0] ws_row,
    output logic [5:0] ws_col,
    output logic       sram_sel,
    output logic [2:0] state_dbg
);

    // Sub-unit handshake: *_start is a one-cycle pulse in the first cycle of a state;
    // the unit answers with a one-cycle *_done pulse some cycles later. Each done is
    // latched in a sticky flag, and the state is left one cycle after every unit it
    // launched has reported. Done pulses in the launch cycle or from idle units are dropped.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEAD_FS = 3'd1,
        S_LEAD_CT = 3'd2,
        S_MEGA_A  = 3'd3,
        S_MEGA_B  = 3'd4,
        S_TAIL_CS = 3'd5,
        S_TAIL_WS = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    // With no chroma columns the frame ends in the Y plane.
    localparam int LAST_PLANE = (UV_BLOCK_COLS == 0) ? 0 : 2;
    localparam int LAST_COLS  = (UV_BLOCK_COLS == 0) ? Y_BLOCK_COLS : UV_BLOCK_COLS;
    localparam logic [12:0] LAST_BLK = {2'(LAST_PLANE), 5'(BLOCK_ROWS - 1), 6'(LAST_COLS - 1)};

    // Block coordinate packed as {plane[1:0], row[4:0], col[5:0]}; saturates at the last block.
    function automatic logic [12:0] next_blk(input logic [12:0] b);
        logic [1:0] p;
        logic [4:0] r;
        logic [5:0] c;
        logic [5:0] cols_m1;
        p = b[12:11];
        r = b[10:6];
        c = b[5:0];
        cols_m1 = (p == 2'd0) ? 6'(Y_BLOCK_COLS - 1) : 6'(UV_BLOCK_COLS - 1);
        if (b == LAST_BLK) begin
            return b;
        end
        if (c == cols_m1) begin
            c = 6'd0;
            if (r == 5'(BLOCK_ROWS - 1)) begin
                r = 5'd0;
                p = p + 2'd1;
            end else begin
                r = r + 5'd1;
            end
        end else begin
            c = c + 6'd1;
        end
        return {p, r, c};
    endfunction

    state_e      state_q, state_d;
    logic        launch_q, launch_d;
    logic [3:0]  flag_q, flag_d;      // {fs, ct, cs, ws}
    logic [12:0] fs_blk_q, fs_blk_d;
    logic [12:0] ws_blk_q, ws_blk_d;

    logic [3:0]  unit_mask;           // units launched by the current state, {fs, ct, cs, ws}
    logic [3:0]  done_in;
    logic        all_done;
    logic [12:0] ws_next;

    assign done_in = {FS_done, CT_done, CS_done, WS_done};

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            launch_q <= 1'b0;
            flag_q   <= 4'b0000;
            fs_blk_q <= 13'd0;
            ws_blk_q <= 13'd0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            flag_q   <= flag_d;
            fs_blk_q <= fs_blk_d;
            ws_blk_q <= ws_blk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fs_blk_d = fs_blk_q;
        ws_blk_d = ws_blk_q;
        ws_next  = next_blk(ws_blk_q);
        all_done = !launch_q && (unit_mask != 4'b0000) && ((flag_q | ~unit_mask) == 4'b1111);

        if (launch_q || (unit_mask == 4'b0000)) begin
            flag_d = 4'b0000;
        end else begin
            flag_d = flag_q | (done_in & unit_mask);
        end

        case (state_q)
            S_IDLE: begin
                if (M2_start) begin
                    state_d  = S_LEAD_FS;
                    fs_blk_d = 13'd0;
                    ws_blk_d = 13'd0;
                end
            end
            S_LEAD_FS: begin
                if (all_done) begin
                    state_d  = S_LEAD_CT;
                    fs_blk_d = next_blk(fs_blk_q);
                end
            end
            S_LEAD_CT: begin
                // A one-block frame has nothing to overlap and goes straight to the tail.
                if (all_done) begin
                    state_d = (ws_blk_q == LAST_BLK) ? S_TAIL_CS : S_MEGA_A;
                end
            end
            S_MEGA_A: begin
                if (all_done) begin
                    state_d  = S_MEGA_B;
                    fs_blk_d = next_blk(fs_blk_q);
                end
            end
            S_MEGA_B: begin
                if (all_done) begin
                    ws_blk_d = ws_next;
                    state_d  = (ws_next == LAST_BLK) ? S_TAIL_CS : S_MEGA_A;
                end
            end
            S_TAIL_CS: begin
                if (all_done) begin
                    state_d = S_TAIL_WS;
                end
            end
            S_TAIL_WS: begin
                if (all_done) begin
                    state_d  = S_DONE;
                    fs_blk_d = 13'd0;
                    ws_blk_d = 13'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        launch_d = (state_d != state_q) && (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_comb begin
        case (state_q)
            S_LEAD_FS: unit_mask = 4'b1000;
            S_LEAD_CT: unit_mask = 4'b0100;
            S_MEGA_A:  unit_mask = 4'b1010;
            S_MEGA_B:  unit_mask = 4'b0101;
            S_TAIL_CS: unit_mask = 4'b0010;
            S_TAIL_WS: unit_mask = 4'b0001;
            default:   unit_mask = 4'b0000;
        endcase

        {FS_start, CT_start, CS_start, WS_start} = launch_q ? unit_mask : 4'b0000;
        sram_sel  = (state_q == S_MEGA_B) || (state_q == S_TAIL_WS);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        M2_done   = (state_q == S_DONE);
        fs_plane  = fs_blk_q[12:11];
        fs_row    = fs_blk_q[10:6];
        fs_col    = fs_blk_q[5:0];
        ws_plane  = ws_blk_q[12:11];
        ws_row    = ws_blk_q[10:6];
        ws_col    = ws_blk_q[5:0];
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_m2_block_sequencer.sv
// Bench for m2_block_sequencer: a 4-block frame instance and a 1-block frame instance,
// each sub-unit answered by a delayed done responder.
module tb_m2_block_sequencer;

    typedef struct {
        logic [3:0]  st;      // {fs, ct, cs, ws} start pattern
        logic [12:0] fs_blk;  // {plane, row, col}
        logic [12:0] ws_blk;
        logic        sram;
    } vec_t;

    logic clk;
    logic rst_n;
    logic a_start, b_start;
    logic [7:0] r_done;
    logic [7:0] i_done;
    int   dly [8];
    int   n_vec = 0;
    int   n_fail = 0;
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;

    logic a_m2_done, a_busy, a_fs_st, a_ct_st, a_cs_st, a_ws_st, a_sram;
    logic [1:0] a_fp, a_wp;
    logic [4:0] a_fr, a_wr;
    logic [5:0] a_fc, a_wc;
    logic [2:0] a_state;
    logic b_m2_done, b_busy, b_fs_st, b_ct_st, b_cs_st, b_ws_st, b_sram;
    logic [1:0] b_fp, b_wp;
    logic [4:0] b_fr, b_wr;
    logic [5:0] b_fc, b_wc;
    logic [2:0] b_state;

    logic [3:0]  a_st, b_st;
    logic [7:0]  st_all;
    logic [12:0] a_fs_blk, a_ws_blk, b_fs_blk, b_ws_blk;
    logic [35:0] a_outs, b_outs;

    assign a_st     = {a_fs_st, a_ct_st, a_cs_st, a_ws_st};
    assign b_st     = {b_fs_st, b_ct_st, b_cs_st, b_ws_st};
    assign st_all   = {b_st, a_st};
    assign a_fs_blk = {a_fp, a_fr, a_fc};
    assign a_ws_blk = {a_wp, a_wr, a_wc};
    assign b_fs_blk = {b_fp, b_fr, b_fc};
    assign b_ws_blk = {b_wp, b_wr, b_wc};
    assign a_outs   = {a_m2_done, a_busy, a_st, a_fs_blk, a_ws_blk, a_sram, a_state};
    assign b_outs   = {b_m2_done, b_busy, b_st, b_fs_blk, b_ws_blk, b_sram, b_state};

    m2_block_sequencer #(.Y_BLOCK_COLS(2), .UV_BLOCK_COLS(1), .BLOCK_ROWS(1)) dut_a (
        .CLOCK_50_I(clk), .Resetn(rst_n), .M2_start(a_start), .M2_done(a_m2_done), .busy(a_busy),
        .FS_start(a_fs_st), .CT_start(a_ct_st), .CS_start(a_cs_st), .WS_start(a_ws_st),
        .FS_done(r_done[3] | i_done[3]), .CT_done(r_done[2] | i_done[2]),
        .CS_done(r_done[1] | i_done[1]), .WS_done(r_done[0] | i_done[0]),
        .fs_plane(a_fp), .fs_row(a_fr), .fs_col(a_fc),
        .ws_plane(a_wp), .ws_row(a_wr), .ws_col(a_wc),
        .sram_sel(a_sram), .state_dbg(a_state)
    );

    m2_block_sequencer #(.Y_BLOCK_COLS(1), .UV_BLOCK_COLS(0), .BLOCK_ROWS(1)) dut_b (
        .CLOCK_50_I(clk), .Resetn(rst_n), .M2_start(b_start), .M2_done(b_m2_done), .busy(b_busy),
        .FS_start(b_fs_st), .CT_start(b_ct_st), .CS_start(b_cs_st), .WS_start(b_ws_st),
        .FS_done(r_done[7] | i_done[7]), .CT_done(r_done[6] | i_done[6]),
        .CS_done(r_done[5] | i_done[5]), .WS_done(r_done[4] | i_done[4]),
        .fs_plane(b_fp), .fs_row(b_fr), .fs_col(b_fc),
        .ws_plane(b_wp), .ws_row(b_wr), .ws_col(b_wc),
        .sram_sel(b_sram), .state_dbg(b_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: each unit pulses done dly[u] cycles after its start pulse.
    initial begin
        int cnt [8];
        r_done = 8'h00;
        for (int u = 0; u < 8; u++) cnt[u] = -1;
        forever begin
            @(negedge clk);
            r_done = 8'h00;
            if (!rst_n) begin
                for (int u = 0; u < 8; u++) cnt[u] = -1;
            end else begin
                for (int u = 0; u < 8; u++) begin
                    if (cnt[u] > 0) begin
                        cnt[u] = cnt[u] - 1;
                        if (cnt[u] == 0) begin
                            r_done[u] = 1'b1;
                            cnt[u] = -1;
                        end
                    end
                    if (st_all[u]) cnt[u] = dly[u];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (a_m2_done) a_done_cnt = a_done_cnt + 1;
            if (b_m2_done) b_done_cnt = b_done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] st, input logic [1:0] fp, input logic [5:0] fc,
                                input logic [1:0] wp, input logic [5:0] wc, input logic sram);
        vec_t v;
        v.st = st;
        v.fs_blk = {fp, 5'd0, fc};
        v.ws_blk = {wp, 5'd0, wc};
        v.sram = sram;
        return v;
    endfunction

    task automatic compare_vec(input int which, input vec_t v, input string tag);
        logic [3:0]  st;
        logic [12:0] fsb, wsb;
        logic        sr, bz;
        st  = (which != 0) ? b_st : a_st;
        fsb = (which != 0) ? b_fs_blk : a_fs_blk;
        wsb = (which != 0) ? b_ws_blk : a_ws_blk;
        sr  = (which != 0) ? b_sram : a_sram;
        bz  = (which != 0) ? b_busy : a_busy;
        check({tag, " starts"}, st, v.st);
        if (v.st[3]) check({tag, " fs_coord"}, fsb, v.fs_blk);
        if (v.st[0]) check({tag, " ws_coord"}, wsb, v.ws_blk);
        check({tag, " sram_sel"}, sr, v.sram);
        check({tag, " busy"}, bz, 1'b1);
    endtask

    task automatic wait_start(input int which, output int gap);
        gap = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            gap = gap + 1;
            if (((which != 0) ? b_st : a_st) != 4'b0000) return;
        end
    endtask

    task automatic wait_done(input int which, output int gap);
        gap = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            gap = gap + 1;
            if (((which != 0) ? b_m2_done : a_m2_done) == 1'b1) return;
        end
    endtask

    task automatic pulse_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic pulse_b();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    // Stimulus and checks
    initial begin
        vec_t tab_a [10];
        vec_t tab_b [4];
        int   gap;
        int   d0;
        logic bad;

        // 4-block frame: Y(0,0,0) Y(0,0,1) U(1,0,0) V(2,0,0)
        tab_a[0] = mk(4'b1000, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_a[1] = mk(4'b0100, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_a[2] = mk(4'b1010, 2'd0, 6'd1, 2'd0, 6'd0, 1'b0);
        tab_a[3] = mk(4'b0101, 2'd0, 6'd0, 2'd0, 6'd0, 1'b1);
        tab_a[4] = mk(4'b1010, 2'd1, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_a[5] = mk(4'b0101, 2'd0, 6'd0, 2'd0, 6'd1, 1'b1);
        tab_a[6] = mk(4'b1010, 2'd2, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_a[7] = mk(4'b0101, 2'd0, 6'd0, 2'd1, 6'd0, 1'b1);
        tab_a[8] = mk(4'b0010, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_a[9] = mk(4'b0001, 2'd0, 6'd0, 2'd2, 6'd0, 1'b1);
        tab_b[0] = mk(4'b1000, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_b[1] = mk(4'b0100, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_b[2] = mk(4'b0010, 2'd0, 6'd0, 2'd0, 6'd0, 1'b0);
        tab_b[3] = mk(4'b0001, 2'd0, 6'd0, 2'd0, 6'd0, 1'b1);

        rst_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        i_done = 8'h00;
        for (int u = 0; u < 8; u++) dly[u] = 5;

        repeat (3) @(negedge clk);
        check("reset a outputs", a_outs, 36'd0);
        check("reset b outputs", b_outs, 36'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (a_outs != 36'd0 || b_outs != 36'd0) bad = 1'b1;
        end
        check("idle 100 cycles", bad, 1'b0);

        // Full 4-block frame, every unit answering after 5 cycles
        d0 = a_done_cnt;
        pulse_a();
        compare_vec(0, tab_a[0], "full[0]");
        for (int i = 1; i < 10; i++) begin
            wait_start(0, gap);
            check($sformatf("full[%0d] gap", i), gap, 7);
            compare_vec(0, tab_a[i], $sformatf("full[%0d]", i));
        end
        wait_done(0, gap);
        check("full done gap", gap, 7);
        check("full busy drops with done", a_busy, 1'b0);
        @(negedge clk);
        check("full done one cycle", a_m2_done, 1'b0);
        check("full back to idle", a_state, 3'd0);
        repeat (3) @(negedge clk);
        check("full done count", a_done_cnt - d0, 1);

        // Skewed and same-cycle completion, stray WS_done in MEGA_A
        d0 = a_done_cnt;
        pulse_a();
        check("skew lead_fs", a_st, 4'b1000);
        wait_start(0, gap);
        check("skew lead_ct", a_st, 4'b0100);
        dly[3] = 40;
        dly[1] = 3;
        wait_start(0, gap);
        check("skew mega_a start", a_st, 4'b1010);
        wait_start(0, gap);
        check("skew hold gap", gap, 42);
        check("skew mega_b start", a_st, 4'b0101);
        dly[3] = 7;
        dly[1] = 7;
        wait_start(0, gap);
        check("same-cycle mega_a start", a_st, 4'b1010);
        wait_start(0, gap);
        check("same-cycle exit gap", gap, 9);
        check("same-cycle mega_b start", a_st, 4'b0101);
        dly[3] = 20;
        dly[1] = 20;
        wait_start(0, gap);
        check("stray mega_a start", a_st, 4'b1010);
        gap = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            i_done[0] = (k == 3);
            gap = k;
            if (k == 10) check("sram_sel in mega_a", a_sram, 1'b0);
            if (a_st != 4'b0000) break;
        end
        i_done[0] = 1'b0;
        check("stray ws_done gap", gap, 22);
        check("stray mega_b start", a_st, 4'b0101);
        check("sram_sel in mega_b", a_sram, 1'b1);
        dly[3] = 5;
        dly[1] = 5;
        wait_done(0, gap);
        check("skew frame done", a_m2_done, 1'b1);
        repeat (3) @(negedge clk);
        check("skew done count", a_done_cnt - d0, 1);

        // Asynchronous reset during MEGA_B of block 2, then a fresh frame
        pulse_a();
        for (int i = 1; i < 8; i++) begin
            wait_start(0, gap);
            check($sformatf("rst run[%0d] gap", i), gap, 7);
        end
        check("rst run mega_b(2)", a_st, 4'b0101);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", a_outs, 36'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_outs != 36'd0) bad = 1'b1;
        end
        check("post reset idle", bad, 1'b0);
        pulse_a();
        check("restart fs_start", a_st, 4'b1000);
        check("restart fs coord", a_fs_blk, 13'd0);
        wait_done(0, gap);
        check("restart frame done", a_m2_done, 1'b1);

        // One-block frame with an ignored second start
        d0 = b_done_cnt;
        pulse_b();
        compare_vec(1, tab_b[0], "one[0]");
        wait_start(1, gap);
        check("one[1] gap", gap, 7);
        compare_vec(1, tab_b[1], "one[1]");
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_start(1, gap);
        check("one[2] gap", gap, 6);
        compare_vec(1, tab_b[2], "one[2]");
        wait_start(1, gap);
        check("one[3] gap", gap, 7);
        compare_vec(1, tab_b[3], "one[3]");
        wait_done(1, gap);
        check("one done gap", gap, 7);
        check("one busy drops", b_busy, 1'b0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (b_st != 4'b0000 || b_busy) bad = 1'b1;
        end
        check("one no restart", bad, 1'b0);
        check("one done count", b_done_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
